// File: rtl/decode_issue.sv
// Two-state RV32I issue stage (R-type, I-ALU, BEQ/BNE) feeding a single-cycle execute stage.
// Owns the PC, the 32x32 register file and the retired-instruction counter.
module decode_issue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic        issue_valid,
   output logic [31:0] pc,
   output logic [1:0]  aluop,
   output logic [2:0]  f3,
   output logic [6:0]  f7,
   output logic [31:0] readdata1,
   output logic [31:0] readdata2,
   output logic [31:0] immgen,
   output logic        alusrc,
   input  logic [31:0] alu_output,
   input  logic        zero_flag,
   input  logic [31:0] pc_branch,
   output logic        illegal,
   output logic [31:0] instret
);
   typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        commit;
   logic        taken;
   logic [31:0] rf [32];
   logic [4:0]  rs1, rs2, rd;
   logic        wr_en, is_beq, is_bne;

   logic [6:0]  opcode;
   logic [2:0]  d_f3;
   logic        d_ok, d_alusrc, d_wr, d_beq, d_bne;
   logic [1:0]  d_aluop;
   logic [6:0]  d_f7;
   logic [31:0] d_imm;

   assign opcode = instr[6:0];
   assign d_f3   = instr[14:12];

   always_comb begin
      d_ok     = 1'b0;
      d_aluop  = 2'b00;
      d_f7     = 7'd0;
      d_imm    = 32'd0;
      d_alusrc = 1'b0;
      d_wr     = 1'b0;
      d_beq    = 1'b0;
      d_bne    = 1'b0;
      case (opcode)
         7'b0110011: begin
            d_ok    = 1'b1;
            d_aluop = 2'b10;
            d_f7    = instr[31:25];
            d_wr    = 1'b1;
         end
         7'b0010011: begin
            d_ok     = 1'b1;
            d_aluop  = 2'b10;
            d_alusrc = 1'b1;
            d_imm    = {{20{instr[31]}}, instr[31:20]};
            d_wr     = 1'b1;
            // only the shift-immediates carry a meaningful funct7
            if (d_f3 == 3'b001 || d_f3 == 3'b101) d_f7 = instr[31:25];
         end
         7'b1100011: begin
            if (d_f3 == 3'b000 || d_f3 == 3'b001) begin
               d_ok    = 1'b1;
               d_aluop = 2'b01;
               d_imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
               d_beq   = (d_f3 == 3'b000);
               d_bne   = (d_f3 == 3'b001);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      issue_valid = 1'b0;
      case (state)
         FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = EXEC;
         end
         EXEC: begin
            issue_valid = 1'b1;
            state_nxt   = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   assign accept = instr_valid && instr_ready;
   assign commit = (state == EXEC);
   assign taken  = (is_beq && zero_flag) || (is_bne && !zero_flag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         instret <= 32'd0;
         illegal <= 1'b0;
         aluop   <= 2'b00;
         f3      <= 3'd0;
         f7      <= 7'd0;
         immgen  <= 32'd0;
         alusrc  <= 1'b0;
         rs1     <= 5'd0;
         rs2     <= 5'd0;
         rd      <= 5'd0;
         wr_en   <= 1'b0;
         is_beq  <= 1'b0;
         is_bne  <= 1'b0;
      end else begin
         if (accept) begin
            if (d_ok) begin
               aluop  <= d_aluop;
               f3     <= d_f3;
               f7     <= d_f7;
               immgen <= d_imm;
               alusrc <= d_alusrc;
               rs1    <= instr[19:15];
               rs2    <= instr[24:20];
               rd     <= instr[11:7];
               wr_en  <= d_wr;
               is_beq <= d_beq;
               is_bne <= d_bne;
            end else begin
               // unsupported word issues as a NOP with every decode output cleared
               aluop   <= 2'b00;
               f3      <= 3'd0;
               f7      <= 7'd0;
               immgen  <= 32'd0;
               alusrc  <= 1'b0;
               rs1     <= 5'd0;
               rs2     <= 5'd0;
               rd      <= 5'd0;
               wr_en   <= 1'b0;
               is_beq  <= 1'b0;
               is_bne  <= 1'b0;
               illegal <= 1'b1;
            end
         end
         if (commit) begin
            pc      <= taken ? pc_branch : pc + 32'd4;
            instret <= instret + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (commit && wr_en && rd != 5'd0) begin
         rf[rd] <= alu_output;
      end
   end

   assign readdata1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
   assign readdata2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected issue/commit records are queued as instructions are
// driven, captured DUT records are queued as they appear, and each scenario drains and compares both.
module tb_decode_issue;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = 32'd0;
   logic        issue_valid;
   logic [31:0] pc;
   logic [1:0]  aluop;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] readdata1, readdata2, immgen;
   logic        alusrc;
   logic [31:0] alu_output = 32'd0;
   logic        zero_flag = 1'b0;
   logic [31:0] pc_branch = 32'd0;
   logic        illegal;
   logic [31:0] instret;

   decode_issue dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .issue_valid(issue_valid), .pc(pc), .aluop(aluop), .f3(f3), .f7(f7),
      .readdata1(readdata1), .readdata2(readdata2), .immgen(immgen), .alusrc(alusrc),
      .alu_output(alu_output), .zero_flag(zero_flag), .pc_branch(pc_branch),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  hs;        // {issue_valid, instr_ready} during EXEC
      logic [1:0]  aluop;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        alusrc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc_issue;
      logic [31:0] pc_next;
      logic [31:0] instret;
      logic        ill;
   } rec_t;

   rec_t sb[$];
   rec_t got[$];

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_pc = 32'd0;
   logic [31:0] m_instret = 32'd0;
   logic        m_ill = 1'b0;

   task automatic send(input logic [31:0] w, input logic [31:0] res, input logic zf,
                       input logic [31:0] pcb);
      rec_t g;
      int   n;
      g = '0;
      @(negedge clk);
      instr = w;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         n_checks++;
         $display("FAIL accept_timeout: instr_ready=%0b after %0d cycles, required 1", instr_ready, n);
         instr_valid = 1'b0;
         got.push_back(g);
         return;
      end
      @(posedge clk);
      #1;
      g.hs = {issue_valid, instr_ready};
      g.aluop = aluop;
      g.f3 = f3;
      g.f7 = f7;
      g.imm = immgen;
      g.alusrc = alusrc;
      g.rd1 = readdata1;
      g.rd2 = readdata2;
      g.pc_issue = pc;
      instr_valid = 1'b0;
      alu_output = res;
      zero_flag = zf;
      pc_branch = pcb;
      @(posedge clk);
      #1;
      g.pc_next = pc;
      g.instret = instret;
      g.ill = illegal;
      got.push_back(g);
   endtask

   // Builds the expected record from the bench's own architectural model, then drives the word.
   task automatic push_send(input logic [31:0] w, input logic [1:0] e_aluop, input logic [2:0] e_f3,
                            input logic [6:0] e_f7, input logic [31:0] e_imm, input logic e_alusrc,
                            input logic [31:0] e_rd1, input logic [31:0] e_rd2, input logic e_ill,
                            input logic [31:0] res, input logic zf, input logic [31:0] pcb);
      rec_t e;
      logic tk;
      e.hs = 2'b10;
      e.aluop = e_aluop;
      e.f3 = e_f3;
      e.f7 = e_f7;
      e.imm = e_imm;
      e.alusrc = e_alusrc;
      e.rd1 = e_rd1;
      e.rd2 = e_rd2;
      e.pc_issue = m_pc;
      tk = (e_aluop == 2'b01) && ((e_f3 == 3'b000 && zf) || (e_f3 == 3'b001 && !zf));
      m_pc = tk ? pcb : m_pc + 32'd4;
      m_instret = m_instret + 32'd1;
      m_ill = m_ill | e_ill;
      e.pc_next = m_pc;
      e.instret = m_instret;
      e.ill = m_ill;
      sb.push_back(e);
      send(w, res, zf, pcb);
   endtask

   task automatic test_reset();
      logic [73:0] obs, req;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      obs = {pc, instret, instr_ready, issue_valid, illegal, aluop, f3, f7, alusrc};
      req = {32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 7'd0, 1'b0};
      if (obs !== req) $display("FAIL reset_state: got %h required %h", obs, req);
      else n_pass++;
      n_checks++;
      if ({immgen, readdata1, readdata2} !== 96'd0)
         $display("FAIL reset_data: got %h required 0", {immgen, readdata1, readdata2});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      // start ADDI x3,x0,9 and pull reset in the middle of its EXEC cycle
      @(negedge clk);
      instr = 32'h0090_0193;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({issue_valid, aluop, immgen} !== {1'b1, 2'b10, 32'd9})
         $display("FAIL reset_pre_exec: got %h required %h", {issue_valid, aluop, immgen}, {1'b1, 2'b10, 32'd9});
      else n_pass++;
      instr_valid = 1'b0;
      alu_output = 32'd9;
      rst_n = 1'b0;
      #1;
      n_checks++;
      obs = {pc, instret, instr_ready, issue_valid, illegal, aluop, f3, f7, alusrc};
      req = {32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 7'd0, 1'b0};
      if (obs !== req) $display("FAIL reset_mid_exec: got %h required %h", obs, req);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({pc, instret, instr_ready} !== {32'd0, 32'd0, 1'b1})
         $display("FAIL reset_no_commit: got %h required %h", {pc, instret, instr_ready}, {32'd0, 32'd0, 1'b1});
      else n_pass++;
      m_pc = 32'd0;
      m_instret = 32'd0;
      m_ill = 1'b0;
   endtask

   task automatic test_alu();
      rec_t e, g;
      push_send(32'h0050_0093, 2'b10, 3'd0, 7'h00, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0, 32'd5, 1'b0, 32'd0);
      push_send(32'h0010_8133, 2'b10, 3'd0, 7'h00, 32'd0, 1'b0, 32'd5, 32'd5, 1'b0, 32'd10, 1'b0, 32'd0);
      push_send(32'hFFF0_0413, 2'b10, 3'd0, 7'h00, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'd0);
      push_send(32'h4030_D393, 2'b10, 3'd5, 7'h20, 32'h0000_0403, 1'b1, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push_send(32'h4011_04B3, 2'b10, 3'd0, 7'h20, 32'd0, 1'b0, 32'd10, 32'd5, 1'b0, 32'd5, 1'b0, 32'd0);
      while (sb.size() > 0 && got.size() > 0) begin
         e = sb.pop_front();
         g = got.pop_front();
         n_checks++;
         if ({g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc} !== {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc})
            $display("FAIL alu_decode: got %h required %h", {g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc}, {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc});
         else n_pass++;
         n_checks++;
         if ({g.rd1, g.rd2} !== {e.rd1, e.rd2})
            $display("FAIL alu_operands: got %h required %h", {g.rd1, g.rd2}, {e.rd1, e.rd2});
         else n_pass++;
         n_checks++;
         if ({g.pc_issue, g.pc_next, g.instret, g.ill} !== {e.pc_issue, e.pc_next, e.instret, e.ill})
            $display("FAIL alu_commit: got %h required %h", {g.pc_issue, g.pc_next, g.instret, g.ill}, {e.pc_issue, e.pc_next, e.instret, e.ill});
         else n_pass++;
      end
   endtask

   task automatic test_branch();
      rec_t e, g;
      push_send(32'h0010_8463, 2'b01, 3'd0, 7'h00, 32'd8, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b1, m_pc + 32'd8);
      push_send(32'h0010_8463, 2'b01, 3'd0, 7'h00, 32'd8, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0, m_pc + 32'd8);
      push_send(32'h0010_9463, 2'b01, 3'd1, 7'h00, 32'd8, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b1, m_pc + 32'd8);
      push_send(32'h0010_9463, 2'b01, 3'd1, 7'h00, 32'd8, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b0, m_pc + 32'd8);
      // backward BEQ x0,x0,-4 steered to the top of the address space
      push_send(32'hFE00_0EE3, 2'b01, 3'd0, 7'h00, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
      while (sb.size() > 0 && got.size() > 0) begin
         e = sb.pop_front();
         g = got.pop_front();
         n_checks++;
         if ({g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc} !== {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc})
            $display("FAIL branch_decode: got %h required %h", {g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc}, {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc});
         else n_pass++;
         n_checks++;
         if ({g.rd1, g.rd2} !== {e.rd1, e.rd2})
            $display("FAIL branch_operands: got %h required %h", {g.rd1, g.rd2}, {e.rd1, e.rd2});
         else n_pass++;
         n_checks++;
         if ({g.pc_issue, g.pc_next, g.instret, g.ill} !== {e.pc_issue, e.pc_next, e.instret, e.ill})
            $display("FAIL branch_commit: got %h required %h", {g.pc_issue, g.pc_next, g.instret, g.ill}, {e.pc_issue, e.pc_next, e.instret, e.ill});
         else n_pass++;
      end
   endtask

   task automatic test_x0_write();
      rec_t e, g;
      // ADDI x0,x0,7 at 0xFFFFFFFC also wraps the PC to 0; ADD x5,x0,x2 then reads x0
      push_send(32'h0070_0013, 2'b10, 3'd0, 7'h00, 32'd7, 1'b1, 32'd0, 32'd0, 1'b0, 32'd7, 1'b0, 32'd0);
      push_send(32'h0020_02B3, 2'b10, 3'd0, 7'h00, 32'd0, 1'b0, 32'd0, 32'd10, 1'b0, 32'd10, 1'b0, 32'd0);
      while (sb.size() > 0 && got.size() > 0) begin
         e = sb.pop_front();
         g = got.pop_front();
         n_checks++;
         if ({g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc} !== {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc})
            $display("FAIL x0_decode: got %h required %h", {g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc}, {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc});
         else n_pass++;
         n_checks++;
         if ({g.rd1, g.rd2} !== {e.rd1, e.rd2})
            $display("FAIL x0_operands: got %h required %h", {g.rd1, g.rd2}, {e.rd1, e.rd2});
         else n_pass++;
         n_checks++;
         if ({g.pc_issue, g.pc_next, g.instret, g.ill} !== {e.pc_issue, e.pc_next, e.instret, e.ill})
            $display("FAIL x0_commit: got %h required %h", {g.pc_issue, g.pc_next, g.instret, g.ill}, {e.pc_issue, e.pc_next, e.instret, e.ill});
         else n_pass++;
      end
   endtask

   task automatic test_illegal();
      rec_t e, g;
      push_send(32'h0000_2183, 2'b00, 3'd0, 7'h00, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
      push_send(32'h0001_8333, 2'b10, 3'd0, 7'h00, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push_send(32'h0000_0003, 2'b00, 3'd0, 7'h00, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0);
      push_send(32'h0000_2063, 2'b00, 3'd0, 7'h00, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 32'h0000_0100);
      while (sb.size() > 0 && got.size() > 0) begin
         e = sb.pop_front();
         g = got.pop_front();
         n_checks++;
         if ({g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc} !== {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc})
            $display("FAIL illegal_decode: got %h required %h", {g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc}, {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc});
         else n_pass++;
         n_checks++;
         if ({g.rd1, g.rd2} !== {e.rd1, e.rd2})
            $display("FAIL illegal_operands: got %h required %h", {g.rd1, g.rd2}, {e.rd1, e.rd2});
         else n_pass++;
         n_checks++;
         if ({g.pc_issue, g.pc_next, g.instret, g.ill} !== {e.pc_issue, e.pc_next, e.instret, e.ill})
            $display("FAIL illegal_commit: got %h required %h", {g.pc_issue, g.pc_next, g.instret, g.ill}, {e.pc_issue, e.pc_next, e.instret, e.ill});
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      rec_t e, g;
      logic [100:0] obs, req;
      push_send(32'h0010_0513, 2'b10, 3'd0, 7'h00, 32'd1, 1'b1, 32'd0, 32'd5, 1'b0, 32'd1, 1'b0, 32'd0);
      push_send(32'h0015_0593, 2'b10, 3'd0, 7'h00, 32'd1, 1'b1, 32'd1, 32'd5, 1'b0, 32'd2, 1'b0, 32'd0);
      push_send(32'h00A5_8633, 2'b10, 3'd0, 7'h00, 32'd0, 1'b0, 32'd2, 32'd1, 1'b0, 32'd3, 1'b0, 32'd0);
      while (sb.size() > 0 && got.size() > 0) begin
         e = sb.pop_front();
         g = got.pop_front();
         n_checks++;
         if ({g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc} !== {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc})
            $display("FAIL b2b_decode: got %h required %h", {g.hs, g.aluop, g.f3, g.f7, g.imm, g.alusrc}, {e.hs, e.aluop, e.f3, e.f7, e.imm, e.alusrc});
         else n_pass++;
         n_checks++;
         if ({g.rd1, g.rd2} !== {e.rd1, e.rd2})
            $display("FAIL b2b_operands: got %h required %h", {g.rd1, g.rd2}, {e.rd1, e.rd2});
         else n_pass++;
         n_checks++;
         if ({g.pc_issue, g.pc_next, g.instret, g.ill} !== {e.pc_issue, e.pc_next, e.instret, e.ill})
            $display("FAIL b2b_commit: got %h required %h", {g.pc_issue, g.pc_next, g.instret, g.ill}, {e.pc_issue, e.pc_next, e.instret, e.ill});
         else n_pass++;
      end
      // idle with no instruction offered: FSM parks in FETCH, state and decode outputs hold
      instr_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      obs = {pc, instret, instr_ready, issue_valid, illegal, aluop, readdata1, readdata2[1:0]};
      req = {m_pc, m_instret, 1'b1, 1'b0, 1'b1, 2'b10, 32'd2, 2'd1};
      if (obs !== req) $display("FAIL idle_hold: got %h required %h", obs, req);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_x0_write();
      test_illegal();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
